// File: rtl/pipe_core_param.sv
// pipe_core_param: three-stage (Decode / Execute / Writeback) integer pipeline.
// Instructions arrive on a valid/ready stream. EX results are forwarded to D,
// and an OUT instruction sitting in EX stalls the pipe until out_ready.
`timescale 1ns/1ps
module pipe_core_param #(
    parameter int WIDTH = 8,
    parameter int NREG  = 8,
    parameter int RA_W  = 3,
    parameter int IW    = 4 + 2*RA_W + WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IW-1:0]    ins,
    input  logic             ins_valid,
    output logic             ins_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             wb_valid,
    output logic [RA_W-1:0]  wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic [3:0]       flags
);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_LDI  = 4'h6,
        OP_MOV  = 4'h7,
        OP_SHL  = 4'h8,
        OP_SHR  = 4'h9,
        OP_IN   = 4'hA,
        OP_OUT  = 4'hB,
        OP_ADDI = 4'hC
    } op_e;

    function automatic logic writes_rf(input op_e op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LDI,
                          OP_MOV, OP_SHL, OP_SHR, OP_IN, OP_ADDI};
    endfunction

    // Register file and pipeline registers
    logic [WIDTH-1:0] r_rf [NREG];
    logic             r_d_valid;
    logic [IW-1:0]    r_d_ins;
    logic             r_ex_valid;
    op_e              r_ex_op;
    logic [RA_W-1:0]  r_ex_rd;
    logic [WIDTH-1:0] r_ex_a;
    logic [WIDTH-1:0] r_ex_b;
    logic             r_wb_valid;
    logic [RA_W-1:0]  r_wb_rd;
    logic [WIDTH-1:0] r_wb_data;
    logic [3:0]       r_flags;

    // Decode-stage fields
    logic [3:0]       w_d_raw;
    op_e              w_d_op;
    logic [RA_W-1:0]  w_d_rd;
    logic [RA_W-1:0]  w_d_rs1;
    logic [RA_W-1:0]  w_d_rs2;
    logic [WIDTH-1:0] w_d_f;
    logic [WIDTH-1:0] w_d_a;
    logic [WIDTH-1:0] w_d_b;

    // Execute-stage results
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic             w_upd;
    logic             w_ex_wr;
    logic             w_stall;

    assign w_d_raw = r_d_ins[IW-1 -: 4];
    // Opcodes D-F carry no behaviour; folding them to NOP here keeps EX decode simple.
    assign w_d_op  = (w_d_raw > 4'hC) ? OP_NOP : op_e'(w_d_raw);
    assign w_d_rd  = r_d_ins[IW-5 -: RA_W];
    assign w_d_rs1 = r_d_ins[IW-5-RA_W -: RA_W];
    assign w_d_f   = r_d_ins[WIDTH-1:0];
    assign w_d_rs2 = w_d_f[RA_W-1:0];

    assign w_sum   = {1'b0, r_ex_a} + {1'b0, r_ex_b};
    assign w_diff  = {1'b0, r_ex_a} - {1'b0, r_ex_b};
    assign w_ex_wr = r_ex_valid & writes_rf(r_ex_op);
    assign w_stall = r_ex_valid & (r_ex_op == OP_OUT) & ~out_ready;

    assign ins_ready = ~w_stall;
    assign out_valid = r_ex_valid & (r_ex_op == OP_OUT);
    assign data_out  = out_valid ? r_ex_a : '0;
    assign wb_valid  = r_wb_valid;
    assign wb_rd     = r_wb_rd;
    assign wb_data   = r_wb_data;
    assign flags     = r_flags;

    // Decode operand fetch with EX->D forwarding; the RF write lands on the same
    // edge the producer leaves EX, so no separate RF bypass is required.
    always_comb begin
        w_d_a = r_rf[w_d_rs1];
        w_d_b = r_rf[w_d_rs2];
        if (w_ex_wr && (r_ex_rd == w_d_rs1)) w_d_a = w_res;
        if (w_ex_wr && (r_ex_rd == w_d_rs2)) w_d_b = w_res;
        if ((w_d_op == OP_LDI) || (w_d_op == OP_ADDI)) w_d_b = w_d_f;
    end

    // Execute ALU: result plus carry/overflow and whether flags update
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_upd = 1'b0;
        case (r_ex_op)
            OP_ADD, OP_ADDI: begin
                w_res = w_sum[MSB:0];
                w_c   = w_sum[WIDTH];
                w_v   = (r_ex_a[MSB] == r_ex_b[MSB]) && (w_sum[MSB] != r_ex_a[MSB]);
                w_upd = 1'b1;
            end
            OP_SUB: begin
                w_res = w_diff[MSB:0];
                w_c   = w_diff[WIDTH];
                w_v   = (r_ex_a[MSB] != r_ex_b[MSB]) && (w_diff[MSB] != r_ex_a[MSB]);
                w_upd = 1'b1;
            end
            OP_AND: begin
                w_res = r_ex_a & r_ex_b;
                w_upd = 1'b1;
            end
            OP_OR: begin
                w_res = r_ex_a | r_ex_b;
                w_upd = 1'b1;
            end
            OP_XOR: begin
                w_res = r_ex_a ^ r_ex_b;
                w_upd = 1'b1;
            end
            OP_SHL: begin
                w_res = {r_ex_a[MSB-1:0], 1'b0};
                w_c   = r_ex_a[MSB];
                w_upd = 1'b1;
            end
            OP_SHR: begin
                w_res = {1'b0, r_ex_a[MSB:1]};
                w_c   = r_ex_a[0];
                w_upd = 1'b1;
            end
            OP_LDI:  w_res = r_ex_b;
            OP_MOV:  w_res = r_ex_a;
            OP_IN:   w_res = data_in;
            default: w_res = '0;
        endcase
    end

    // D and EX stage registers; both hold while an OUT waits for out_ready
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_d_valid  <= 1'b0;
            r_d_ins    <= '0;
            r_ex_valid <= 1'b0;
            r_ex_op    <= OP_NOP;
            r_ex_rd    <= '0;
            r_ex_a     <= '0;
            r_ex_b     <= '0;
        end else if (!w_stall) begin
            r_d_valid  <= ins_valid;
            if (ins_valid) r_d_ins <= ins;
            r_ex_valid <= r_d_valid;
            r_ex_op    <= w_d_op;
            r_ex_rd    <= w_d_rd;
            r_ex_a     <= w_d_a;
            r_ex_b     <= w_d_b;
        end
    end

    // WB register: retires register-writing ops, bubble otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
        end else begin
            r_wb_valid <= w_ex_wr & ~w_stall;
            if (w_ex_wr && !w_stall) begin
                r_wb_rd   <= r_ex_rd;
                r_wb_data <= w_res;
            end
        end
    end

    // Register file write on the edge the producer leaves EX
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) r_rf[i] <= '0;
        end else if (w_ex_wr && !w_stall) begin
            r_rf[r_ex_rd] <= w_res;
        end
    end

    // Flags {Z,N,C,V} update only for arithmetic, logic and shift ops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= '0;
        end else if (r_ex_valid && w_upd && !w_stall) begin
            r_flags <= {(w_res == '0), w_res[MSB], w_c, w_v};
        end
    end
endmodule

// File: tb/tb_pipe_core_param.sv
// Directed, table-driven bench for pipe_core_param (8-bit and 16-bit instances).
`timescale 1ns/1ps
module tb_pipe_core_param;
    logic        clk = 1'b0;
    logic        reset;
    logic [17:0] ins;
    logic        ins_valid, ins_ready;
    logic [7:0]  data_in, data_out;
    logic        out_valid, out_ready;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [7:0]  wb_data;
    logic [3:0]  flags;

    logic [27:0] ins16;
    logic        iv16, rdy16, ov16, wbv16;
    logic [15:0] din16, dout16, wbd16;
    logic [3:0]  wbrd16, fl16;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_core_param u_dut (
        .clk(clk), .reset(reset), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .data_in(data_in), .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flags(flags)
    );

    pipe_core_param #(.WIDTH(16), .NREG(16), .RA_W(4)) u_dut16 (
        .clk(clk), .reset(reset), .ins(ins16), .ins_valid(iv16), .ins_ready(rdy16),
        .data_in(din16), .data_out(dout16), .out_valid(ov16), .out_ready(1'b1),
        .wb_valid(wbv16), .wb_rd(wbrd16), .wb_data(wbd16), .flags(fl16)
    );

    typedef struct {
        logic [17:0] ins;
        logic        iv;
        logic        ordy;
        logic [7:0]  din;
        logic        e_rdy;
        logic        e_ov;
        logic [7:0]  e_do;
        logic        e_wbv;
        logic [2:0]  e_rd;
        logic [7:0]  e_wd;
        logic [3:0]  e_fl;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [17:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [7:0] f);
        return {op, rd, rs1, f};
    endfunction

    function automatic logic [27:0] mk16(input logic [3:0] op, input logic [3:0] rd,
                                         input logic [3:0] rs1, input logic [15:0] f);
        return {op, rd, rs1, f};
    endfunction

    task automatic add(input logic [17:0] i, input logic iv, input logic ordy, input logic [7:0] din,
                       input logic rdy, input logic ov, input logic [7:0] dout,
                       input logic wbv, input logic [2:0] rd, input logic [7:0] wd, input logic [3:0] fl);
        vec_t t;
        t.ins = i; t.iv = iv; t.ordy = ordy; t.din = din;
        t.e_rdy = rdy; t.e_ov = ov; t.e_do = dout;
        t.e_wbv = wbv; t.e_rd = rd; t.e_wd = wd; t.e_fl = fl;
        tbl.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; ins = '0; ins_valid = 1'b0; out_ready = 1'b1; data_in = '0;
        ins16 = '0; iv16 = 1'b0; din16 = '0;

        // Rows: ins, valid, out_ready, data_in | pre-edge: ins_ready, out_valid, data_out
        //       | post-edge: wb_valid, wb_rd, wb_data, flags {Z,N,C,V}
        add(mk(4'h6,1,0,8'h05), 1,1,8'h00, 1,0,8'h00, 0,0,8'h00, 4'h0); // LDI r1,5
        add(mk(4'h6,2,0,8'h03), 1,1,8'h00, 1,0,8'h00, 0,0,8'h00, 4'h0); // LDI r2,3
        add(mk(4'h1,3,1,8'h02), 1,1,8'h00, 1,0,8'h00, 1,1,8'h05, 4'h0); // ADD r3,r1,r2
        add(mk(4'h0,0,0,8'h00), 0,1,8'h00, 1,0,8'h00, 1,2,8'h03, 4'h0);
        add(mk(4'h0,0,0,8'h00), 0,1,8'h00, 1,0,8'h00, 1,3,8'h08, 4'h0);
        add(mk(4'h6,1,0,8'h7F), 1,1,8'h00, 1,0,8'h00, 0,0,8'h00, 4'h0); // LDI r1,7F
        add(mk(4'hC,2,1,8'h01), 1,1,8'h00, 1,0,8'h00, 0,0,8'h00, 4'h0); // ADDI r2,r1,1
        add(mk(4'h2,3,2,8'h02), 1,1,8'h00, 1,0,8'h00, 1,1,8'h7F, 4'h0); // SUB r3,r2,r2
        add(mk(4'h0,0,0,8'h00), 0,1,8'h00, 1,0,8'h00, 1,2,8'h80, 4'h5);
        add(mk(4'h0,0,0,8'h00), 0,1,8'h00, 1,0,8'h00, 1,3,8'h00, 4'h8);
        add(mk(4'h6,1,0,8'hA5), 1,1,8'h00, 1,0,8'h00, 0,0,8'h00, 4'h8); // LDI r1,A5
        add(mk(4'hB,0,1,8'h00), 1,1,8'h00, 1,0,8'h00, 0,0,8'h00, 4'h8); // OUT r1
        add(mk(4'h1,4,1,8'h01), 1,1,8'h00, 1,0,8'h00, 1,1,8'hA5, 4'h8); // ADD r4,r1,r1
        for (int i = 0; i < 4; i++)                                       // 4 stall cycles
            add(mk(4'h7,5,4,8'h00), 1,0,8'h00, 0,1,8'hA5, 0,0,8'h00, 4'h8); // MOV r5,r4 waits
        add(mk(4'h7,5,4,8'h00), 1,1,8'h00, 1,1,8'hA5, 0,0,8'h00, 4'h8); // OUT retires
        add(mk(4'h0,0,0,8'h00), 0,1,8'h00, 1,0,8'h00, 1,4,8'h4A, 4'h3);
        add(mk(4'h0,0,0,8'h00), 0,1,8'h00, 1,0,8'h00, 1,5,8'h4A, 4'h3);
        add(mk(4'hA,4,0,8'h00), 1,1,8'h3C, 1,0,8'h00, 0,0,8'h00, 4'h3); // IN r4
        add(mk(4'h8,5,4,8'h00), 1,1,8'h3C, 1,0,8'h00, 0,0,8'h00, 4'h3); // SHL r5,r4
        add(mk(4'h9,6,5,8'h00), 1,1,8'h3C, 1,0,8'h00, 1,4,8'h3C, 4'h3); // SHR r6,r5
        add(mk(4'h0,0,0,8'h00), 0,1,8'h00, 1,0,8'h00, 1,5,8'h78, 4'h0);
        add(mk(4'h0,0,0,8'h00), 0,1,8'h00, 1,0,8'h00, 1,6,8'h3C, 4'h0);
        add(mk(4'h9,7,1,8'h00), 1,1,8'h00, 1,0,8'h00, 0,0,8'h00, 4'h0); // SHR r7,r1
        add(mk(4'h0,0,0,8'h00), 0,1,8'h00, 1,0,8'h00, 0,0,8'h00, 4'h0);
        add(mk(4'h0,0,0,8'h00), 0,1,8'h00, 1,0,8'h00, 1,7,8'h52, 4'h2);
        add(mk(4'h5,2,1,8'h01), 1,1,8'h00, 1,0,8'h00, 0,0,8'h00, 4'h2); // XOR r2,r1,r1
        add(mk(4'h0,0,0,8'h00), 0,1,8'h00, 1,0,8'h00, 0,0,8'h00, 4'h2);
        add(mk(4'h0,0,0,8'h00), 0,1,8'h00, 1,0,8'h00, 1,2,8'h00, 4'h8);
        add(mk(4'hD,3,3,8'h00), 1,1,8'h00, 1,0,8'h00, 0,0,8'h00, 4'h8); // opcode D
        add(mk(4'h0,0,0,8'h00), 0,1,8'h00, 1,0,8'h00, 0,0,8'h00, 4'h8);
        add(mk(4'h0,0,0,8'h00), 0,1,8'h00, 1,0,8'h00, 0,0,8'h00, 4'h8);

        // Reset state
        #3;
        chk("rst.wb_valid", 32'(wb_valid), 32'd0);
        chk("rst.wb_rd", 32'(wb_rd), 32'd0);
        chk("rst.wb_data", 32'(wb_data), 32'd0);
        chk("rst.flags", 32'(flags), 32'd0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.data_out", 32'(data_out), 32'd0);
        chk("rst16.flags", 32'(fl16), 32'd0);
        #9 reset = 1'b0;
        #1 chk("rst.ins_ready", 32'(ins_ready), 32'd1);
        tick();

        for (int i = 0; i < tbl.size(); i++) begin
            ins = tbl[i].ins; ins_valid = tbl[i].iv; out_ready = tbl[i].ordy; data_in = tbl[i].din;
            #1;
            chk($sformatf("r%0d.ins_ready", i), 32'(ins_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("r%0d.out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("r%0d.data_out", i), 32'(data_out), 32'(tbl[i].e_do));
            tick();
            chk($sformatf("r%0d.wb_valid", i), 32'(wb_valid), 32'(tbl[i].e_wbv));
            if (tbl[i].e_wbv) begin
                chk($sformatf("r%0d.wb_rd", i), 32'(wb_rd), 32'(tbl[i].e_rd));
                chk($sformatf("r%0d.wb_data", i), 32'(wb_data), 32'(tbl[i].e_wd));
            end
            chk($sformatf("r%0d.flags", i), 32'(flags), 32'(tbl[i].e_fl));
        end

        // Reset asserted in the middle of an OUT stall
        ins = mk(4'hB,0,1,8'h00); ins_valid = 1'b1; out_ready = 1'b0;
        tick();
        ins_valid = 1'b0;
        tick();
        chk("stall.out_valid", 32'(out_valid), 32'd1);
        chk("stall.data_out", 32'(data_out), 32'hA5);
        chk("stall.ins_ready", 32'(ins_ready), 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("midrst.out_valid", 32'(out_valid), 32'd0);
        chk("midrst.data_out", 32'(data_out), 32'd0);
        chk("midrst.wb_valid", 32'(wb_valid), 32'd0);
        chk("midrst.flags", 32'(flags), 32'd0);
        #1 reset = 1'b0; out_ready = 1'b1;
        #1 chk("postrst.ins_ready", 32'(ins_ready), 32'd1);
        @(posedge clk); #1;
        ins = mk(4'h7,7,1,8'h00); ins_valid = 1'b1;   // MOV r7,r1 (r1 cleared)
        tick();
        ins_valid = 1'b0;
        tick();
        chk("mov.wb_valid_early", 32'(wb_valid), 32'd0);
        tick();
        chk("mov.wb_valid", 32'(wb_valid), 32'd1);
        chk("mov.wb_rd", 32'(wb_rd), 32'd7);
        chk("mov.wb_data", 32'(wb_data), 32'd0);

        // 16-bit, 16-register instance
        ins16 = mk16(4'h6,4'hF,4'h0,16'hFFFF); iv16 = 1'b1;   // LDI r15,FFFF
        tick();
        ins16 = mk16(4'hC,4'hE,4'hF,16'h0001);                // ADDI r14,r15,1
        tick();
        iv16 = 1'b0;
        tick();
        chk("w16.wb_valid0", 32'(wbv16), 32'd1);
        chk("w16.wb_rd0", 32'(wbrd16), 32'd15);
        chk("w16.wb_data0", 32'(wbd16), 32'hFFFF);
        tick();
        chk("w16.wb_valid1", 32'(wbv16), 32'd1);
        chk("w16.wb_rd1", 32'(wbrd16), 32'd14);
        chk("w16.wb_data1", 32'(wbd16), 32'h0000);
        chk("w16.flags", 32'(fl16), 32'hA);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
